// File: rtl/spram_stream_loader.sv
// Frame buffer controller: streams words into a single-port RAM, then reads the
// frame back out through a 2-entry skid FIFO that hides the RAM read latency.
module spram_stream_loader #(
  parameter int AWIDTH    = 11,
  parameter int NUM_WORDS = 2048,
  parameter int DWIDTH    = 60
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  input  logic              start_drain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [AWIDTH:0]   frame_len,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out
);

  localparam int CW = AWIDTH + 1;

  typedef enum logic [1:0] {S_FILL, S_FULL, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   frame_len_q, frame_len_d;

  logic [DWIDTH-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              head_q, tail_q;
  logic [1:0]        count_q;
  logic              infl_q, infl_last_q;

  logic       accept, pop, issue, rd_is_last;
  logic [1:0] occ;

  assign in_ready   = resetn && (state_q == S_FILL) && (wr_ptr_q < CW'(NUM_WORDS));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (count_q != 2'd0);
  assign out_data   = out_valid ? fifo_data_q[head_q] : '0;
  assign out_last   = out_valid && fifo_last_q[head_q];
  assign pop        = out_valid && out_ready;
  assign frame_len  = frame_len_q;
  assign busy       = (state_q != S_FILL);
  assign ram_data   = in_data;
  assign rd_is_last = (rd_ptr_q == frame_len_q - CW'(1));

  // A pop this cycle frees its slot in time for the word issued now, which is
  // what keeps the drain bubble-free; buffered + in-flight never exceeds 2.
  assign occ   = count_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue = (state_q == S_DRAIN) && (rd_ptr_q < frame_len_q) && (occ < 2'd2);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    ram_wren    = 1'b0;
    ram_address = '0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          ram_wren    = 1'b1;
          ram_address = wr_ptr_q[AWIDTH-1:0];
          wr_ptr_d    = wr_ptr_q + CW'(1);
          frame_len_d = wr_ptr_q + CW'(1);
          if (in_last || (wr_ptr_q == CW'(NUM_WORDS - 1))) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (start_drain) begin
          state_d  = S_DRAIN;
          rd_ptr_d = '0;
        end
      end
      S_DRAIN: begin
        if (issue) begin
          ram_address = rd_ptr_q[AWIDTH-1:0];
          rd_ptr_d    = rd_ptr_q + CW'(1);
        end
        if (pop && out_last) begin
          state_d     = S_FILL;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          frame_len_d = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
    end
  end

  // ram_out carries the word issued last cycle; infl_q marks it for capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      count_q        <= 2'd0;
      infl_q         <= 1'b0;
      infl_last_q    <= 1'b0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue && rd_is_last;
      if (pop) head_q <= ~head_q;
      if (infl_q) begin
        fifo_data_q[tail_q] <= ram_out;
        fifo_last_q[tail_q] <= infl_last_q;
        tail_q              <= ~tail_q;
      end
      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spram_stream_loader.sv
// Directed bench for spram_stream_loader with a behavioural 2048x60 RAM that
// returns read data one cycle after the address is presented.
module tb_spram_stream_loader;

  localparam int AWIDTH = 11;
  localparam int NUM_WORDS = 2048;
  localparam int DWIDTH = 60;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid, in_ready, in_last;
  logic [DWIDTH-1:0] in_data;
  logic              start_drain;
  logic              out_valid, out_ready, out_last;
  logic [DWIDTH-1:0] out_data;
  logic [AWIDTH:0]   frame_len;
  logic              busy;
  logic [AWIDTH-1:0] ram_address;
  logic              ram_wren;
  logic [DWIDTH-1:0] ram_data, ram_out;

  int checks = 0;
  int errors = 0;

  logic [DWIDTH-1:0] ram_mem [NUM_WORDS];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_out <= ram_mem[ram_address];
  end

  spram_stream_loader #(.AWIDTH(AWIDTH), .NUM_WORDS(NUM_WORDS), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .start_drain(start_drain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_len(frame_len), .busy(busy),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_out(ram_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int start, input logic [DWIDTH-1:0] base,
                      input bit with_last);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DWIDTH'(i);
      in_last  = with_last && (i == n - 1);
      #1;
      if (in_ready !== 1'b1 || ram_wren !== 1'b1 || ram_address !== AWIDTH'(start + i)
          || ram_data !== in_data) bad++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("fill: %0d words at addr %0d, base 0x%0h, last=%0d, frame_len=%0d",
             n, start, base, with_last, frame_len);
    check("fill_handshake", bad, 0);
  endtask

  // stop: number of words to pop before returning; strict: out_ready held high
  // and the first word must appear 2 cycles after the start edge with no gaps.
  task automatic drain(input int n, input logic [DWIDTH-1:0] base, input int stop,
                       input bit strict, input bit rand_ready);
    int idx = 0, cyc = 0, first = -1, last_cyc = 0, gaps = 0;
    int bad_data = 0, bad_last = 0, bad_stall = 0, bad_wr = 0;
    logic              pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DWIDTH-1:0] pd = '0;
    int limit = 4 * n + 64;
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    while (idx < stop && cyc < limit) begin
      if (!rand_ready) out_ready = 1'b1;
      else if (cyc >= 6 && cyc < 18) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      #1;
      if (ram_wren !== 1'b0 || in_ready !== 1'b0) bad_wr++;
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) bad_stall++;
      if (out_valid && out_ready) begin
        if (out_data !== base + DWIDTH'(idx)) bad_data++;
        if (out_last !== (idx == n - 1)) bad_last++;
        if (first < 0) first = cyc;
        else if (cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        idx++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    $display("drain: %0d of %0d words popped in %0d cycles, base 0x%0h", idx, n, cyc, base);
    check("drain_count", idx, stop);
    check("drain_data", bad_data, 0);
    check("drain_last", bad_last, 0);
    check("drain_stall_hold", bad_stall, 0);
    check("drain_no_write", bad_wr, 0);
    if (strict) begin
      check("drain_first_latency", first, 2);
      check("drain_gaps", gaps, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_frame_len"}, frame_len, 0);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b1; in_data = 60'hABC; in_last = 1'b1;
    start_drain = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_data = in_data + 60'h1;
      start_drain = ~start_drain;
    end
    $display("reset: pins toggled for 3 cycles");
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_frame_len", frame_len, 0);
    resetn = 1'b1; in_valid = 1'b0; in_last = 1'b0; start_drain = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // 5-word frame, drained with out_ready high
    fill(5, 0, 60'h1, 1'b1);
    check("f5_frame_len", frame_len, 5);
    check("f5_busy", busy, 1);
    check("f5_in_ready", in_ready, 0);
    drain(5, 60'h1, 5, 1'b1, 1'b0);
    check_idle("f5_after");

    // start_drain in FILL is ignored; in_valid in FULL/DRAIN is refused
    fill(3, 0, 60'h100, 1'b0);
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    check("ign_busy", busy, 0);
    check("ign_in_ready", in_ready, 1);
    check("ign_frame_len", frame_len, 3);
    fill(7, 3, 60'h103, 1'b1);
    check("f10_frame_len", frame_len, 10);
    in_valid = 1'b1; in_data = 60'hDEAD;
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_no_wren", ram_wren, 0);
    tick();
    check("full_frame_len_held", frame_len, 10);
    check("full_busy", busy, 1);
    drain(10, 60'h100, 10, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_idle("f10_after");

    // maximum frame, implicit full after word 2047
    fill(NUM_WORDS, 0, 60'h0, 1'b0);
    check("fmax_in_ready", in_ready, 0);
    check("fmax_frame_len", frame_len, NUM_WORDS);
    check("fmax_busy", busy, 1);
    drain(NUM_WORDS, 60'h0, NUM_WORDS, 1'b1, 1'b0);
    check_idle("fmax_after");

    // reset after 3 of 8 words drained, then a fresh 2-word frame
    fill(8, 0, 60'h200, 1'b1);
    drain(8, 60'h200, 3, 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    $display("reset: asserted mid-drain");
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_len", frame_len, 0);
    resetn = 1'b1;
    tick();
    fill(2, 0, 60'hA0, 1'b1);
    check("f2_frame_len", frame_len, 2);
    drain(2, 60'hA0, 2, 1'b1, 1'b0);
    check_idle("f2_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
